// File: rtl/adc_spi_capture.sv
// SPI receive framer for an AD7476-style ADC: gates SCLK, shifts in one
// 16-bit frame per request and presents the 12-bit result with a valid strobe.
module adc_spi_capture #(
  parameter int FRAME_BITS  = 16,
  parameter int DATA_BITS   = 12,
  parameter int QUIET_EDGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sclk_in,
  input  logic                 start,
  input  logic                 miso,
  output logic                 cs_n,
  output logic                 sclk_out,
  output logic [DATA_BITS-1:0] sample_out,
  output logic                 sample_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int BCW = $clog2(FRAME_BITS + 1);
  localparam int QCW = $clog2(QUIET_EDGES + 1);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SHIFT,
    STOP,
    QUIET
  } state_t;

  state_t                 state, state_d;
  logic                   sclk_q;
  logic                   rise, fall;
  logic [FRAME_BITS-1:0]  shreg, shreg_d;
  logic [BCW-1:0]         bit_cnt, bit_cnt_d;
  logic [QCW-1:0]         quiet_cnt, quiet_cnt_d;
  logic                   cs_n_d;
  logic [DATA_BITS-1:0]   sample_d;
  logic                   sample_valid_d;
  logic                   frame_err_d;

  // The ADC always sends zeros ahead of the data; anything else means a bad frame.
  function automatic logic lead_nonzero(input logic [FRAME_BITS-DATA_BITS-1:0] lead);
    return |lead;
  endfunction

  assign rise = sclk_in & ~sclk_q;
  assign fall = ~sclk_in & sclk_q;
  assign busy = (state != IDLE);

  always_comb begin
    state_d        = state;
    shreg_d        = shreg;
    bit_cnt_d      = bit_cnt;
    quiet_cnt_d    = quiet_cnt;
    cs_n_d         = cs_n;
    sample_d       = sample_out;
    sample_valid_d = 1'b0;
    frame_err_d    = frame_err;
    case (state)
      IDLE: begin
        if (start) state_d = ARM;
      end
      ARM: begin
        if (fall) begin
          cs_n_d    = 1'b0;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (rise) begin
          shreg_d   = {shreg[FRAME_BITS-2:0], miso};
          bit_cnt_d = bit_cnt + 1'b1;
          if (bit_cnt == BCW'(FRAME_BITS - 1)) state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          cs_n_d         = 1'b1;
          sample_d       = shreg[DATA_BITS-1:0];
          frame_err_d    = lead_nonzero(shreg[FRAME_BITS-1:DATA_BITS]);
          sample_valid_d = 1'b1;
          quiet_cnt_d    = '0;
          state_d        = QUIET;
        end
      end
      QUIET: begin
        if (fall) begin
          quiet_cnt_d = quiet_cnt + 1'b1;
          if (quiet_cnt == QCW'(QUIET_EDGES - 1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register stage: sclk_out tracks the next sclk_q so it stays aligned with cs_n.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sclk_q       <= 1'b0;
      shreg        <= '0;
      bit_cnt      <= '0;
      quiet_cnt    <= '0;
      cs_n         <= 1'b1;
      sclk_out     <= 1'b1;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_d;
      sclk_q       <= sclk_in;
      shreg        <= shreg_d;
      bit_cnt      <= bit_cnt_d;
      quiet_cnt    <= quiet_cnt_d;
      cs_n         <= cs_n_d;
      sclk_out     <= cs_n_d | sclk_in;
      sample_out   <= sample_d;
      sample_valid <= sample_valid_d;
      frame_err    <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_adc_spi_capture.sv
// Bench for adc_spi_capture: ADC serial model, divided-clock generator and
// a scoreboard of expected samples popped on every sample_valid.
module tb_adc_spi_capture;

  logic        clk;
  logic        reset;
  logic        sclk_in;
  logic        start;
  logic        miso;
  logic        cs_n;
  logic        sclk_out;
  logic [11:0] sample_out;
  logic        sample_valid;
  logic        frame_err;
  logic        busy;

  adc_spi_capture dut (
    .clk          (clk),
    .reset        (reset),
    .sclk_in      (sclk_in),
    .start        (start),
    .miso         (miso),
    .cs_n         (cs_n),
    .sclk_out     (sclk_out),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  typedef struct {
    logic [15:0] frame;
    int          half;
    logic [11:0] exp_sample;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [11:0] sample;
    logic        err;
  } exp_t;

  vec_t        vecs[6];
  exp_t        sb_q[$];
  logic [15:0] adc_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int half    = 1;
  int valid_cnt = 0;
  int cs_fall_cnt = 0;
  int rises = 0;
  int sclk_viol = 0;
  int hi_len = 0;
  int gap_min = 1000000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic check_le(input string name, input int got, input int bound);
    n_tests++;
    if (got > bound) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected at most %0d", name, got, bound);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Divided serial clock: toggles every 'half' clk cycles.
  initial begin
    int hc;
    hc = 0;
    sclk_in = 1'b0;
    forever begin
      @(negedge clk);
      hc++;
      if (hc >= half) begin
        hc = 0;
        sclk_in = ~sclk_in;
      end
    end
  end

  // ADC model + output monitor. First bit appears with cs_n low, the next on each pin SCLK rise.
  initial begin
    logic        prev_cs, prev_sclk, prev_valid;
    logic [15:0] cur_frame;
    int          idx;
    exp_t        e;
    prev_cs = 1'b1; prev_sclk = 1'b1; prev_valid = 1'b0;
    cur_frame = 16'h0; idx = 16;
    miso = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_cs && !cs_n) begin
        cs_fall_cnt++;
        check("cs_fall_with_sclk_low", sclk_out, 1'b0);
        if (hi_len < gap_min) gap_min = hi_len;
        hi_len = 0;
        if (adc_q.size() > 0) cur_frame = adc_q.pop_front();
        else cur_frame = 16'h0;
        idx = 0;
        rises = 0;
      end
      if (cs_n) hi_len++;
      if (!cs_n && sclk_out && !prev_sclk) begin
        rises++;
        idx++;
      end
      if (cs_n && !sclk_out) sclk_viol++;
      miso = (!cs_n && idx < 16) ? cur_frame[15-idx] : 1'b0;
      if (sample_valid) begin
        valid_cnt++;
        check("valid_width", prev_valid, 1'b0);
        check("rises_per_frame", rises, 16);
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid: got sample %0h, expected no sample", sample_out);
        end else begin
          e = sb_q.pop_front();
          check("sample_out", sample_out, e.sample);
          check("frame_err", frame_err, e.err);
        end
      end
      prev_cs = cs_n;
      prev_sclk = sclk_out;
      prev_valid = sample_valid;
    end
  end

  task automatic expect_frame(input logic [15:0] frame, input logic [11:0] s, input logic err);
    exp_t e;
    e.sample = s;
    e.err = err;
    adc_q.push_back(frame);
    sb_q.push_back(e);
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int cycles);
    int base;
    base = valid_cnt;
    cycles = 0;
    while (valid_cnt == base && cycles < budget) begin
      tick();
      cycles++;
    end
    if (valid_cnt == base) begin
      n_tests++;
      n_fail++;
      $display("FAIL valid_timeout: got no sample_valid, expected one within %0d clk", budget);
    end
  endtask

  initial begin
    int cyc;
    int base;
    int guard;
    vecs[0] = '{16'h0ABC, 1, 12'hABC, 1'b0};
    vecs[1] = '{16'h8123, 1, 12'h123, 1'b1};
    vecs[2] = '{16'h0ABC, 4, 12'hABC, 1'b0};
    vecs[3] = '{16'h0000, 1, 12'h000, 1'b0};
    vecs[4] = '{16'h0FFF, 2, 12'hFFF, 1'b0};
    vecs[5] = '{16'hF000, 3, 12'h000, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_sclk_out", sclk_out, 1'b1);
    check("rst_sample_out", sample_out, 12'h000);
    check("rst_sample_valid", sample_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      half = vecs[i].half;
      repeat (4 * half) tick();
      sclk_viol = 0;
      expect_frame(vecs[i].frame, vecs[i].exp_sample, vecs[i].exp_err);
      pulse_start();
      wait_valid(100 * half, cyc);
      check_le("latency", cyc, 18 * 2 * half + 2);
      repeat (4 * half - 1) tick();
      check("busy_in_quiet", busy, 1'b1);
      tick();
      check("busy_after_quiet", busy, 1'b0);
      check("sclk_high_while_cs_high", sclk_viol, 0);
    end

    // Reset after the 7th rise discards the partial frame.
    half = 1;
    repeat (4) tick();
    expect_frame(16'h0456, 12'h456, 1'b0);
    pulse_start();
    guard = 0;
    while (!(cs_n == 1'b0 && rises == 7) && guard < 200) begin
      tick();
      guard++;
    end
    check("reached_7th_rise", rises, 7);
    reset = 1'b1;
    tick();
    check("midrst_cs_n", cs_n, 1'b1);
    check("midrst_sclk_out", sclk_out, 1'b1);
    check("midrst_sample_out", sample_out, 12'h000);
    check("midrst_sample_valid", sample_valid, 1'b0);
    check("midrst_frame_err", frame_err, 1'b0);
    check("midrst_busy", busy, 1'b0);
    if (sb_q.size() > 0) void'(sb_q.pop_back());
    reset = 1'b0;
    repeat (3) tick();
    expect_frame(16'h0456, 12'h456, 1'b0);
    pulse_start();
    wait_valid(200, cyc);
    repeat (10) tick();

    // Start pulsed mid-frame is ignored.
    base = valid_cnt;
    expect_frame(16'h0321, 12'h321, 1'b0);
    pulse_start();
    guard = 0;
    while (!(cs_n == 1'b0 && rises >= 4) && guard < 200) begin
      tick();
      guard++;
    end
    pulse_start();
    wait_valid(200, cyc);
    repeat (120) tick();
    check("single_valid_for_mid_start", valid_cnt - base, 1);
    check("idle_after_mid_start", busy, 1'b0);

    // Back-to-back frames with start held high.
    base = cs_fall_cnt;
    expect_frame(16'h0001, 12'h001, 1'b0);
    expect_frame(16'h07FF, 12'h7FF, 1'b0);
    expect_frame(16'h0FFF, 12'hFFF, 1'b0);
    sclk_viol = 0;
    tick();
    start = 1'b1;
    guard = 0;
    while (cs_fall_cnt < base + 3 && guard < 2000) begin
      tick();
      guard++;
    end
    start = 1'b0;
    check("b2b_frames_started", cs_fall_cnt - base, 3);
    gap_min = 1000000;
    base = valid_cnt;
    wait_valid(300, cyc);
    check("b2b_last_valid", valid_cnt - base, 1);
    n_tests++;
    if (gap_min < 4) begin
      n_fail++;
      $display("FAIL b2b_cs_gap: got %0d clk, expected at least 4", gap_min);
    end
    check("b2b_sclk_high_while_cs_high", sclk_viol, 0);
    repeat (20) tick();
    check("scoreboard_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
